// File: rtl/y86_mem_stage_if.sv
// Request/response bus between the execute/write-back side of the Y-86 SEQ
// core and the data-memory stage.
//   master : core side; drives the request (icode, valE, valA, valP,
//            req_valid) and resp_ready, observes req_ready and the response.
//   slave  : memory stage; the mirror image of master.
// The request is one beat of icode plus operands; the response is one beat
// of valM plus mem_err.
interface y86_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] valM;
  logic        mem_err;

  modport master (
    output req_valid, icode, valE, valA, valP, resp_ready,
    input  req_ready, resp_valid, valM, mem_err
  );

  modport slave (
    input  req_valid, icode, valE, valA, valP, resp_ready,
    output req_ready, resp_valid, valM, mem_err
  );
endinterface

// File: rtl/y86_mem_stage.sv
// Handshaked data-memory stage for the Y-86 SEQ processor.
// Accepts one request at a time, waits LATENCY cycles, then performs a
// little-endian DATA_BYTES-wide read or write on an internal byte array and
// presents valM/mem_err until the response is taken.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : y86_mem_stage_if.slave (request and response handshakes)
// Parameters: DEPTH (bytes), DATA_BYTES (bytes per access), LATENCY (>= 1).
module y86_mem_stage #(
  parameter int DEPTH      = 1024,
  parameter int DATA_BYTES = 8,
  parameter int LATENCY    = 1
) (
  input logic             clk,
  input logic             rst_n,
  y86_mem_stage_if.slave  bus
);

  localparam int WB = 8 * DATA_BYTES;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(DEPTH - DATA_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic           access_q;
  logic           write_q;
  logic [63:0]    addr_q;
  logic [WB-1:0]  wdata_q;
  logic [63:0]    valm_q;
  logic           mem_err_q;
  logic           req_ready_q;
  logic           resp_valid_q;

  logic [7:0]     mem [DEPTH];

  logic           dec_access;
  logic           dec_write;
  logic [63:0]    dec_addr;
  logic [63:0]    dec_wdata;
  logic           range_err;
  logic           done;
  logic           commit;
  logic [AW-1:0]  base;
  logic [WB-1:0]  rd_word;

  // Decode the incoming icode into access kind, address and write data.
  // Only sampled on the accepting edge, so the operands may change freely
  // at any other time.
  always_comb begin
    dec_access = 1'b0;
    dec_write  = 1'b0;
    dec_addr   = bus.valE;
    dec_wdata  = bus.valA;
    case (bus.icode)
      4'h4: begin dec_access = 1'b1; dec_write = 1'b1; end
      4'h5: begin dec_access = 1'b1; end
      4'h8: begin dec_access = 1'b1; dec_write = 1'b1; dec_wdata = bus.valP; end
      4'h9: begin dec_access = 1'b1; dec_addr = bus.valA; end
      4'hA: begin dec_access = 1'b1; dec_write = 1'b1; end
      4'hB: begin dec_access = 1'b1; dec_addr = bus.valA; end
      default: ;
    endcase
  end

  // Full 64-bit compare so huge addresses never alias into the array.
  assign range_err = access_q && (addr_q > MAX_ADDR);
  assign base      = addr_q[AW-1:0];
  assign done      = (state == BUSY) && (count == '0);
  assign commit    = done && write_q && !range_err;

  // Little-endian gather of the addressed word; only consumed when in range.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  // Byte array is deliberately not reset. Reset forces IDLE asynchronously,
  // so a write pending in BUSY can never commit.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        mem[base + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake outputs and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      access_q     <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      valm_q       <= '0;
      mem_err_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            access_q    <= dec_access;
            write_q     <= dec_write;
            addr_q      <= dec_addr;
            wdata_q     <= dec_wdata[WB-1:0];
            count       <= CW'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (count == '0) begin
            mem_err_q    <= range_err;
            valm_q       <= (access_q && !write_q && !range_err) ? 64'(rd_word) : 64'd0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.valM       = valm_q;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_y86_mem_stage.sv
// Self-checking bench for y86_mem_stage (DEPTH=1024, DATA_BYTES=8,
// LATENCY=3). A byte-array reference model predicts every response.
module tb_y86_mem_stage;

  localparam int DEPTH      = 1024;
  localparam int DATA_BYTES = 8;
  localparam int LATENCY    = 3;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  bit [7:0] ref_mem [DEPTH];

  y86_mem_stage_if bus ();

  y86_mem_stage #(
    .DEPTH      (DEPTH),
    .DATA_BYTES (DATA_BYTES),
    .LATENCY    (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, need finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic reportTimeout(input string tag);
    tests++;
    failed++;
    $error("[TB] FAIL %s: got timeout, expected handshake", tag);
  endtask

  // Reference model: decode, range-check and little-endian access in
  // plain byte arithmetic.
  task automatic modelAccess(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                             input logic [63:0] p, output logic [63:0] m, output logic err);
    longint unsigned addr;
    logic [63:0] data;
    bit acc;
    bit wr;
    acc = 1'b1; wr = 1'b0; addr = e; data = a;
    case (ic)
      4'h4: wr = 1'b1;
      4'h5: ;
      4'h8: begin wr = 1'b1; data = p; end
      4'h9: addr = a;
      4'hA: wr = 1'b1;
      4'hB: addr = a;
      default: acc = 1'b0;
    endcase
    m = 64'd0;
    err = acc && (addr > longint'(DEPTH - DATA_BYTES));
    if (acc && !err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (wr) ref_mem[addr + i] = data[8*i +: 8];
        else    m = m | (64'(ref_mem[addr + i]) << (8 * i));
      end
    end
  endtask

  // Drives one request, waits for acceptance and the response, optionally
  // holds backpressure for 'hold' cycles (with an intruding request if
  // 'intrude' is set), then completes the response handshake.
  task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                               input logic [63:0] p, input int hold, input bit intrude,
                               output logic [63:0] m, output logic err, output int lat);
    int guard;
    logic rdy;
    m = '0; err = 1'b0; lat = -1;
    bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p;
    bus.req_valid = 1'b1;
    guard = 0;
    do begin
      rdy = bus.req_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 20);
    bus.req_valid = 1'b0;
    if (!rdy) begin
      reportTimeout("accept");
      return;
    end
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin
      checkOutput("busy_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) begin
      reportTimeout("response");
      return;
    end
    m = bus.valM;
    err = bus.mem_err;
    if (intrude) begin
      bus.icode = 4'h4; bus.valE = 64'd300; bus.valA = 64'hDEAD_BEEF_0BAD_F00D;
      bus.req_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_resp_valid", 64'(bus.resp_valid), 64'd1);
      checkOutput("hold_valM", bus.valM, m);
      checkOutput("hold_mem_err", 64'(bus.mem_err), 64'(err));
      checkOutput("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    checkOutput("resp_drop", 64'(bus.resp_valid), 64'd0);
    checkOutput("ready_back", 64'(bus.req_ready), 64'd1);
  endtask

  // Full transaction: model prediction, DUT run, and result comparison.
  task automatic doTxn(input string tag, input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p, input int hold, input bit intrude);
    logic [63:0] em, om;
    logic ee, oe;
    int lat;
    modelAccess(ic, e, a, p, em, ee);
    applyStimulus(ic, e, a, p, hold, intrude, om, oe, lat);
    checkOutput({tag, "_valM"}, om, em);
    checkOutput({tag, "_mem_err"}, 64'(oe), 64'(ee));
    checkOutput({tag, "_latency"}, 64'(lat), 64'(LATENCY));
  endtask

  function automatic logic [63:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6)      return 64'($urandom_range(0, DEPTH - DATA_BYTES));
    else if (r == 7) return 64'($urandom_range(DEPTH - DATA_BYTES + 1, DEPTH - 1));
    else if (r == 8) return 64'(DEPTH - DATA_BYTES);
    else             return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [3:0] ic_tab [9];
    logic [3:0] ic;
    logic [63:0] e, a, p;
    int guard;
    logic rdy;
    ic_tab = '{4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h7};
    tests = 0;
    failed = 0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.icode = 4'h0; bus.valE = '0; bus.valA = '0; bus.valP = '0;

    // Reset values while held in reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("rst_valM", bus.valM, 64'd0);
    checkOutput("rst_mem_err", 64'(bus.mem_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Give every byte a known value so the model covers the whole array.
    for (int w = 0; w < DEPTH / DATA_BYTES; w++)
      doTxn("fill", 4'h4, 64'(w * DATA_BYTES), {32'($urandom), 32'($urandom)}, 64'd0, 0, 1'b0);

    // Write then read, plus neighbouring reads exposing byte order.
    doTxn("push100", 4'hA, 64'd100, 64'h0102030405060708, 64'd0, 0, 1'b0);
    doTxn("read100", 4'h5, 64'd100, 64'd0, 64'd0, 0, 1'b0);
    doTxn("read93",  4'h5, 64'd93,  64'd0, 64'd0, 0, 1'b0);
    doTxn("read107", 4'h5, 64'd107, 64'd0, 64'd0, 0, 1'b0);

    // Boundaries.
    doTxn("bnd1016", 4'h5, 64'd1016, 64'd0, 64'd0, 0, 1'b0);
    doTxn("bnd1017", 4'h5, 64'd1017, 64'd0, 64'd0, 0, 1'b0);
    doTxn("bndwrap", 4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1122334455667788, 64'd0, 0, 1'b0);
    doTxn("bndchk0", 4'h5, 64'd0, 64'd0, 64'd0, 0, 1'b0);
    doTxn("bndchk1", 4'h5, 64'd1016, 64'd0, 64'd0, 0, 1'b0);

    // Call / ret.
    doTxn("call200", 4'h8, 64'd200, 64'd0, 64'h42, 0, 1'b0);
    doTxn("ret200",  4'h9, 64'd0, 64'd200, 64'd0, 0, 1'b0);

    // Backpressure with an intruding request that must be ignored.
    doTxn("bp", 4'h5, 64'd100, 64'd0, 64'd0, 5, 1'b1);
    doTxn("bp300", 4'h5, 64'd300, 64'd0, 64'd0, 0, 1'b0);

    // No-access icode.
    doTxn("nop2", 4'h2, 64'd100, 64'd100, 64'd5, 0, 1'b0);

    // Reset in the middle of BUSY on a write: write must be discarded.
    bus.icode = 4'h4; bus.valE = 64'd500; bus.valA = 64'hCAFE_F00D_1234_5678;
    bus.req_valid = 1'b1;
    guard = 0;
    do begin
      rdy = bus.req_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 20);
    bus.req_valid = 1'b0;
    if (!rdy) reportTimeout("rst_accept");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("midrst_valM", bus.valM, 64'd0);
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_resp_valid2", 64'(bus.resp_valid), 64'd0);
    checkOutput("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    doTxn("midrst_read", 4'h5, 64'd500, 64'd0, 64'd0, 0, 1'b0);

    // Randomised mix against the model.
    for (int n = 0; n < 60; n++) begin
      ic = ic_tab[$urandom_range(0, 8)];
      e  = randAddr();
      p  = {32'($urandom), 32'($urandom)};
      if (ic == 4'h9 || ic == 4'hB) a = randAddr();
      else                          a = {32'($urandom), 32'($urandom)};
      doTxn("rand", ic, e, a, p, $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
